pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central sequencing controller for the 4-slot Riscv151 pipeline: IF (pc0), ID (pc1), EX (pc2), WB (pc3).
- Generates the clock-enables for the PC register and the three stage registers, plus per-stage valid bits.
- Handles the post-reset boot window, taken-branch squash, load-use interlock and global memory stall.
- Sits beside the datapath; it holds no datapath state of its own.

Parameters:
- BOOT_CYCLES, 1: cycles after reset release during which the PC is held while the first fetch is issued (range 1..15).
- FLUSH_DEPTH, 2: wrong-path instruction slots killed per taken branch (range 2..7).

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset.
- stall, input, 1: memory-system stall (icache/dcache); freezes the whole pipeline.
- branch_taken, input, 1: EX-stage redirect (PC select); meaningful only when ex_valid=1.
- ex_is_load, input, 1: instruction in EX is a load.
- ex_rd, input, 5: destination register of the EX instruction.
- id_rs1, input, 5: ID-stage source register 1.
- id_rs2, input, 5: ID-stage source register 2.
- id_uses_rs1, input, 1: ID instruction reads rs1.
- id_uses_rs2, input, 1: ID instruction reads rs2.
- pc_ce, output, 1: PC register enable.
- id_ce, output, 1: IF->ID register enable.
- ex_ce, output, 1: ID->EX register enable.
- wb_ce, output, 1: EX->WB register enable.
- icache_re, output, 1: instruction fetch read enable.
- id_valid, output, 1: ID slot holds a correct-path instruction.
- ex_valid, output, 1: EX slot holds a correct-path instruction.
- wb_valid, output, 1: WB slot holds a correct-path instruction.
- ctrl_state, output, 2: current state, for debug (BOOT=0, RUN=1, FLUSH=2).

Behaviour:
- Reset (sync, active-high): state=BOOT, boot counter=BOOT_CYCLES-1, squash counter=0, id_valid=ex_valid=wb_valid=0.
- While reset=1: all *_ce=0, icache_re=0.
- stall=1 has top priority:
  - All *_ce=0; icache_re=1.
  - Valid bits, state and counters hold; no branch or interlock is acted on.
- BOOT:
  - pc_ce=0; id_ce=ex_ce=wb_ce=1; icache_re=1.
  - The counter decrements each unstalled cycle. At 0 -> RUN, and id_valid is set to 1 on that transition (first instruction enters ID).
- RUN / FLUSH, unstalled:
  - wb_valid<=ex_valid.
  - ex_valid<=id_valid & !interlock & !redirect.
  - id_valid<=!redirect & !(state==FLUSH).
- redirect = ex_valid & branch_taken (combinational).
  - On redirect: pc_ce=1 (PC loads target); the ID and IF slots are squashed (2 slots).
  - If FLUSH_DEPTH>2: squash counter<=FLUSH_DEPTH-3 and state->FLUSH.
- FLUSH:
  - Each unstalled cycle forces id_valid<=0.
  - At counter 0 -> RUN; otherwise decrement.
  - Any branch_taken arriving with ex_valid=0 is ignored.
- interlock = !redirect & ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - On interlock: pc_ce=0, id_ce=0, ex_ce=1, wb_ce=1; one bubble goes into EX; id_valid holds.
  - Next cycle the load is in WB and the condition is false.
- Otherwise in RUN: all *_ce=1, icache_re=1.
- Simultaneous redirect + interlock: redirect wins; interlock is suppressed by definition.
- x0 as ex_rd never interlocks.
- Reset mid-FLUSH or mid-interlock: full return to BOOT next edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_bubbles[31:0] and perf_flushes[31:0]. Both reset to 0 and wrap at 2^32.
  - perf_bubbles increments on each unstalled RUN/FLUSH cycle where ex_valid is written 0.
  - perf_flushes increments once per redirect.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset high 3 cycles, then low, with BOOT_CYCLES=1 -> ctrl_state=0 for 1 cycle, pc_ce=0, then RUN; id_valid=1 next cycle; ex_valid 1 a cycle later; wb_valid one after.
- Steady RUN, redirect with ex_valid=1, branch_taken=1 -> pc_ce=1 that cycle; next cycle id_valid=0, ex_valid=0; following cycle wb_valid=0. With FLUSH_DEPTH=4: two extra cycles of id_valid=0, ctrl_state=2, then ctrl_state=1.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_ce=id_ce=0 for exactly 1 cycle; next ex_valid=0; id_valid stays 1. Repeat with ex_rd=0 -> no interlock.
- stall=1 for 4 cycles during a pending redirect -> all *_ce=0, valid bits frozen; redirect is acted on in the first cycle after stall=0.
- Redirect and interlock conditions true together -> pc_ce=1, no ID hold. Reset asserted mid-FLUSH -> ctrl_state=0, all valids 0 next edge.
- PIPE_CTRL_PERF_EN defined, 3 redirects plus 1 interlock -> perf_flushes=3, perf_bubbles=7 (FLUSH_DEPTH=2: 3×2 + 1).

Source files
------------

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 4-slot IF/ID/EX/WB pipeline: stage enables, valid bits, boot, squash, interlock, stall.
// Optional perf counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       pc_ce,
  output logic       id_ce,
  output logic       ex_ce,
  output logic       wb_ce,
  output logic       icache_re,
  output logic       id_valid,
  output logic       ex_valid,
  output logic       wb_valid,
  output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);
  // The redirect itself kills ID and IF; FLUSH only covers the slots beyond those two.
  localparam int         SQ_INT    = (FLUSH_DEPTH > 2) ? FLUSH_DEPTH - 3 : 0;
  localparam logic [2:0] SQ_INIT   = 3'(SQ_INT);

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [2:0] squash_cnt_q, squash_cnt_d;
  logic       id_valid_q, id_valid_d;
  logic       ex_valid_q, ex_valid_d;
  logic       wb_valid_q, wb_valid_d;

  logic       redirect;
  logic       interlock;
  logic       rs_hit;

  assign redirect  = ex_valid_q & branch_taken;
  assign rs_hit    = (id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd));
  assign interlock = ~redirect & ex_valid_q & ex_is_load & (ex_rd != 5'd0) & id_valid_q & rs_hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= BOOT_INIT;
      squash_cnt_q <= 3'd0;
      id_valid_q   <= 1'b0;
      ex_valid_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      squash_cnt_q <= squash_cnt_d;
      id_valid_q   <= id_valid_d;
      ex_valid_q   <= ex_valid_d;
      wb_valid_q   <= wb_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    squash_cnt_d = squash_cnt_q;
    id_valid_d   = id_valid_q;
    ex_valid_d   = ex_valid_q;
    wb_valid_d   = wb_valid_q;
    if (!stall) begin
      case (state_q)
        ST_BOOT: begin
          if (boot_cnt_q == 4'd0) begin
            state_d    = ST_RUN;
            id_valid_d = 1'b1;
          end else begin
            boot_cnt_d = boot_cnt_q - 4'd1;
          end
        end
        default: begin
          wb_valid_d = ex_valid_q;
          ex_valid_d = id_valid_q & ~interlock & ~redirect;
          id_valid_d = ~redirect & (state_q != ST_FLUSH);
          if (redirect) begin
            if (FLUSH_DEPTH > 2) begin
              state_d      = ST_FLUSH;
              squash_cnt_d = SQ_INIT;
            end else begin
              state_d = ST_RUN;
            end
          end else if (state_q == ST_FLUSH) begin
            if (squash_cnt_q == 3'd0) begin
              state_d = ST_RUN;
            end else begin
              squash_cnt_d = squash_cnt_q - 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_ce     = 1'b0;
    id_ce     = 1'b0;
    ex_ce     = 1'b0;
    wb_ce     = 1'b0;
    icache_re = 1'b0;
    if (!reset) begin
      icache_re = 1'b1;
      if (!stall) begin
        if (state_q == ST_BOOT) begin
          id_ce = 1'b1;
          ex_ce = 1'b1;
          wb_ce = 1'b1;
        end else if (interlock) begin
          ex_ce = 1'b1;
          wb_ce = 1'b1;
        end else begin
          pc_ce = 1'b1;
          id_ce = 1'b1;
          ex_ce = 1'b1;
          wb_ce = 1'b1;
        end
      end
    end
  end

  assign id_valid   = id_valid_q;
  assign ex_valid   = ex_valid_q;
  assign wb_valid   = wb_valid_q;
  assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic        run_adv;

  assign run_adv = ~stall & (state_q != ST_BOOT);

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (run_adv && !ex_valid_d) perf_bubbles_d = perf_bubbles_q + 32'd1;
    if (run_adv && redirect)    perf_flushes_d = perf_flushes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_q <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a slot-level pipeline model (boot countdown, kill budget, valid shift).
module tb_pipe_ctrl;

  localparam int BOOT_CYCLES = 3;
  localparam int FLUSH_DEPTH = 4;
  localparam int N_CYCLES    = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       pc_ce, id_ce, ex_ce, wb_ce, icache_re;
  logic       id_valid, ex_valid, wb_valid;
  logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  pipe_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .branch_taken(branch_taken),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .pc_ce       (pc_ce),
    .id_ce       (id_ce),
    .ex_ce       (ex_ce),
    .wb_ce       (wb_ce),
    .icache_re   (icache_re),
    .id_valid    (id_valid),
    .ex_valid    (ex_valid),
    .wb_valid    (wb_valid),
    .ctrl_state  (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: remaining boot cycles, wrong-path fetches still to kill, and the valid of each slot.
  int          boot_left;
  int          kill_left;
  bit          m_id, m_ex, m_wb;
  int unsigned m_bub, m_fl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    boot_left = BOOT_CYCLES;
    kill_left = 0;
    m_id = 1'b0;
    m_ex = 1'b0;
    m_wb = 1'b0;
    m_bub = 0;
    m_fl = 0;
  endtask

  function automatic bit m_redirect();
    return (boot_left == 0) && m_ex && branch_taken;
  endfunction

  function automatic bit m_interlock();
    bit hit;
    hit = (id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd));
    return !m_redirect() && (boot_left == 0) && m_ex && m_id && ex_is_load && (ex_rd != 5'd0) && hit;
  endfunction

  task automatic check_outputs();
    bit e_pc, e_id, e_ex, e_wb, e_ic;
    int e_st;
    e_pc = 0; e_id = 0; e_ex = 0; e_wb = 0; e_ic = 0;
    if (!reset) begin
      e_ic = 1;
      if (!stall) begin
        e_id = !m_interlock();
        e_ex = 1;
        e_wb = 1;
        e_pc = (boot_left == 0) && !m_interlock();
      end
    end
    e_st = (boot_left > 0) ? 0 : (kill_left > 0) ? 2 : 1;
    check("pc_ce",      32'(pc_ce),      32'(e_pc));
    check("id_ce",      32'(id_ce),      32'(e_id));
    check("ex_ce",      32'(ex_ce),      32'(e_ex));
    check("wb_ce",      32'(wb_ce),      32'(e_wb));
    check("icache_re",  32'(icache_re),  32'(e_ic));
    check("id_valid",   32'(id_valid),   32'(m_id));
    check("ex_valid",   32'(ex_valid),   32'(m_ex));
    check("wb_valid",   32'(wb_valid),   32'(m_wb));
    check("ctrl_state", 32'(ctrl_state), 32'(e_st));
  endtask

  task automatic model_step();
    bit redir, ilk, new_id;
    if (reset) begin
      model_reset();
    end else if (stall) begin
      // pipeline frozen
    end else if (boot_left > 0) begin
      boot_left--;
      if (boot_left == 0) m_id = 1'b1;
    end else begin
      redir = m_redirect();
      ilk   = m_interlock();
      m_wb  = m_ex;
      if (redir) begin
        m_ex = 1'b0;
        m_id = 1'b0;
        kill_left = FLUSH_DEPTH - 2;
        m_fl++;
      end else begin
        new_id = (kill_left == 0);
        if (kill_left > 0) kill_left--;
        m_ex = m_id && !ilk;
        m_id = new_id;
      end
      if (!m_ex) m_bub++;
    end
  endtask

  // Driver
  task automatic drive_random();
    reset        = (cyc > 8) && ($urandom_range(0, 99) < 2);
    stall        = ($urandom_range(0, 99) < 20);
    branch_taken = ($urandom_range(0, 99) < 12);
    ex_is_load   = ($urandom_range(0, 1) == 1);
    ex_rd        = 5'($urandom_range(0, 3));
    id_rs1       = 5'($urandom_range(0, 3));
    id_rs2       = 5'($urandom_range(0, 3));
    id_uses_rs1  = ($urandom_range(0, 1) == 1);
    id_uses_rs2  = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; ex_is_load = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    for (int i = 0; i < N_CYCLES; i++) begin
      cyc = i;
      @(negedge clk);
      drive_random();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
    end
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b1;
    #1;
    check("perf_bubbles", perf_bubbles, m_bub);
    check("perf_flushes", perf_flushes, m_fl);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
